// File: rtl/riscv_pkg.sv
// riscv_pkg
//   Shared core definitions: data/address width and the fetch buffer entry type.
//   fetch_buf_entry_t pairs an instruction word with the PC it was fetched from.
package riscv_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] instr;
  } fetch_buf_entry_t;

endpackage

// File: rtl/fifo_sync.sv
// fifo_sync
//   Generic single-clock circular buffer with push, pop, flush and occupancy count.
//   DEPTH must be a power of two so the pointers wrap without extra compare logic.
// Ports
//   clk      in   clock, rising edge
//   reset    in   asynchronous active-high reset
//   push_i   in   write data_i at the tail (ignored when full and not popping)
//   data_i   in   WIDTH-bit write data
//   pop_i    in   drop the head entry (ignored when empty)
//   flush_i  in   empty the buffer; overrides push and pop
//   data_o   out  head entry
//   count_o  out  entries held, 0..DEPTH
module fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  input  logic                       flush_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i & (count_q != '0);
  // A full buffer still accepts a push when the head leaves in the same cycle.
  assign do_push = push_i & ((count_q != CW'(DEPTH)) | do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (do_push && !flush_i) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// fetch_buffer
//   Decoupling instruction queue between the icache and decode. Issues sequential
//   fetches over a valid/ready port, reserves queue space per outstanding request,
//   and drops responses made stale by a redirect.
//   Optional feature macro: FETCH_BUF_BYPASS_EN -- a non-stale response arriving at
//   an empty queue while decode is ready goes straight to decode in the same cycle.
// Ports
//   clk, reset                      clock / asynchronous active-high reset
//   reset_adr_i                     first fetch PC after reset
//   redirect_v_i, redirect_pc_i     flush and restart fetch at redirect_pc_i
//   icache_req_v_o/_rdy_i/_adr_o    fetch request handshake and address
//   icache_rsp_v_i, icache_instr_i  in-order fetch response
//   instr_v_o, instr_o, pc_o        head entry to decode
//   instr_rdy_i                     decode consumes head
//   occupancy_o                     entries currently queued
module fetch_buffer
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [XLEN-1:0]            reset_adr_i,
  input  logic                       redirect_v_i,
  input  logic [XLEN-1:0]            redirect_pc_i,
  output logic                       icache_req_v_o,
  input  logic                       icache_req_rdy_i,
  output logic [XLEN-1:0]            icache_adr_o,
  input  logic                       icache_rsp_v_i,
  input  logic [31:0]                icache_instr_i,
  output logic                       instr_v_o,
  output logic [31:0]                instr_o,
  output logic [XLEN-1:0]            pc_o,
  input  logic                       instr_rdy_i,
  output logic [$clog2(DEPTH+1)-1:0] occupancy_o
);

  localparam int unsigned CW = $clog2(DEPTH+1);
  localparam int unsigned SW = CW + 1;

  logic [XLEN-1:0]  fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]    in_flight_q, in_flight_d, stale_q, stale_d;
  logic [CW-1:0]    count;
  fetch_buf_entry_t head, push_entry;
  logic             q_valid, req_acc, rsp_ok, rsp_live, bypass, push, pop;

  assign q_valid = (count != '0);

  // Space for every in-flight response is reserved up front, so a response never stalls.
  assign icache_req_v_o = !reset && !redirect_v_i
                          && ((SW'(count) + SW'(in_flight_q)) < SW'(DEPTH))
                          && (in_flight_q < CW'(MAX_OUTSTANDING));
  assign icache_adr_o   = fetch_pc_q;
  assign req_acc        = icache_req_v_o & icache_req_rdy_i;

  // A response with nothing in flight is a protocol error and is ignored.
  assign rsp_ok   = icache_rsp_v_i & (in_flight_q != '0);
  assign rsp_live = rsp_ok & (stale_q == '0);

`ifdef FETCH_BUF_BYPASS_EN
  assign bypass = rsp_live & !q_valid & instr_rdy_i & !redirect_v_i;
`else
  assign bypass = 1'b0;
`endif

  assign push = rsp_live & !redirect_v_i & !bypass;
  assign pop  = q_valid & !redirect_v_i & instr_rdy_i;

  assign push_entry.pc    = rsp_pc_q;
  assign push_entry.instr = icache_instr_i;

  fifo_sync #(
    .WIDTH($bits(fetch_buf_entry_t)),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push_i (push),
    .data_i (push_entry),
    .pop_i  (pop),
    .flush_i(redirect_v_i),
    .data_o (head),
    .count_o(count)
  );

  assign instr_v_o   = (q_valid & !redirect_v_i) | bypass;
  assign instr_o     = bypass ? icache_instr_i : head.instr;
  assign pc_o        = bypass ? rsp_pc_q : head.pc;
  assign occupancy_o = count;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    in_flight_d = in_flight_q;
    stale_d     = stale_q;
    if (req_acc) begin
      fetch_pc_d  = fetch_pc_q + XLEN'(4);
      in_flight_d = in_flight_q + CW'(1);
    end
    if (rsp_ok) begin
      in_flight_d = in_flight_d - CW'(1);
      if (stale_q != '0) stale_d  = stale_q - CW'(1);
      else               rsp_pc_d = rsp_pc_q + XLEN'(4);
    end
    // Every request still outstanding after this cycle's response belongs to the old stream.
    if (redirect_v_i) begin
      fetch_pc_d = redirect_pc_i;
      rsp_pc_d   = redirect_pc_i;
      stale_d    = in_flight_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc_q  <= reset_adr_i;
      rsp_pc_q    <= reset_adr_i;
      in_flight_q <= '0;
      stale_q     <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      in_flight_q <= in_flight_d;
      stale_q     <= stale_d;
    end
  end

  a_rsp_needs_request: assert property (@(posedge clk) disable iff (reset)
    icache_rsp_v_i |-> (in_flight_q != '0));

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;
  import riscv_pkg::*;

  localparam int DEPTH = 4;
  localparam int MAXO  = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   reset_adr_i;
  logic          redirect_v_i;
  logic [31:0]   redirect_pc_i;
  logic          icache_req_v_o;
  logic          icache_req_rdy_i;
  logic [31:0]   icache_adr_o;
  logic          icache_rsp_v_i;
  logic [31:0]   icache_instr_i;
  logic          instr_v_o;
  logic [31:0]   instr_o;
  logic [31:0]   pc_o;
  logic          instr_rdy_i;
  logic [CW-1:0] occupancy_o;

  fetch_buffer #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)) dut (
    .clk             (clk),
    .reset           (reset),
    .reset_adr_i     (reset_adr_i),
    .redirect_v_i    (redirect_v_i),
    .redirect_pc_i   (redirect_pc_i),
    .icache_req_v_o  (icache_req_v_o),
    .icache_req_rdy_i(icache_req_rdy_i),
    .icache_adr_o    (icache_adr_o),
    .icache_rsp_v_i  (icache_rsp_v_i),
    .icache_instr_i  (icache_instr_i),
    .instr_v_o       (instr_v_o),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .instr_rdy_i     (instr_rdy_i),
    .occupancy_o     (occupancy_o)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // icache behaviour knobs (percent chance per cycle)
  int unsigned ic_rdy_pct = 100;
  int unsigned ic_rsp_pct = 100;

  logic [31:0] pending[$];   // addresses accepted by the icache, not yet answered
  logic [31:0] acc_log[$];
  int          acc_cnt = 0;
  int          pop_cnt = 0;

  // reference model: expected fetch PC, PC of next instruction owed to decode,
  // entries queued, requests in flight, responses still to be discarded
  logic [31:0] m_fetch, m_head;
  int          m_cnt, m_infl, m_stale;

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    if (pc == 32'h8000_0400) return 32'h0000_0013;
    return (pc * 32'h9E37_79B1) ^ 32'h5A5A_0003;
  endfunction

  // icache responder: in order, at least one cycle after accept
  initial begin
    icache_req_rdy_i = 1'b0;
    icache_rsp_v_i   = 1'b0;
    icache_instr_i   = '0;
    forever begin
      @(posedge clk); #1;
      icache_req_rdy_i = ($urandom_range(99) < ic_rdy_pct);
      if (!reset && pending.size() > 0 && $urandom_range(99) < ic_rsp_pct) begin
        icache_rsp_v_i = 1'b1;
        icache_instr_i = instr_of(pending[0]);
      end else begin
        icache_rsp_v_i = 1'b0;
        icache_instr_i = $urandom;
      end
    end
  end

  // cycle monitor: compares against the model, then advances it by one cycle
  always @(negedge clk) begin
    bit exp_req, exp_iv, byp, acc, rsp, pop_m;
    if (reset) begin
      checks++;
      if (icache_req_v_o !== 1'b0 || instr_v_o !== 1'b0 || occupancy_o !== '0 ||
          instr_o !== '0 || pc_o !== '0 || icache_adr_o !== reset_adr_i) begin
        failures++;
        $display("FAIL reset_outputs req_v=%0b instr_v=%0b occ=%0d instr=%h pc=%h adr=%h required zeros and adr=%h",
                 icache_req_v_o, instr_v_o, occupancy_o, instr_o, pc_o, icache_adr_o, reset_adr_i);
      end
      m_fetch = reset_adr_i;
      m_head  = reset_adr_i;
      m_cnt   = 0;
      m_infl  = 0;
      m_stale = 0;
      pending.delete();
    end else begin
      exp_req = !redirect_v_i && (m_cnt + m_infl < DEPTH) && (m_infl < MAXO);
`ifdef FETCH_BUF_BYPASS_EN
      byp = (m_cnt == 0) && icache_rsp_v_i && (m_stale == 0) && instr_rdy_i && !redirect_v_i;
`else
      byp = 1'b0;
`endif
      exp_iv = ((m_cnt != 0) && !redirect_v_i) || byp;

      checks++;
      if (icache_req_v_o !== exp_req) begin
        failures++;
        $display("FAIL req_v got=%0b exp=%0b (cnt=%0d infl=%0d) t=%0t", icache_req_v_o, exp_req, m_cnt, m_infl, $time);
      end
      checks++;
      if (icache_adr_o !== m_fetch) begin
        failures++;
        $display("FAIL fetch_adr got=%h exp=%h t=%0t", icache_adr_o, m_fetch, $time);
      end
      checks++;
      if (occupancy_o !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL occupancy got=%0d exp=%0d t=%0t", occupancy_o, m_cnt, $time);
      end
      checks++;
      if (instr_v_o !== exp_iv) begin
        failures++;
        $display("FAIL instr_v got=%0b exp=%0b t=%0t", instr_v_o, exp_iv, $time);
      end
      if (instr_v_o === 1'b1 && exp_iv) begin
        checks++;
        if (pc_o !== m_head || instr_o !== instr_of(m_head)) begin
          failures++;
          $display("FAIL head pc=%h instr=%h exp pc=%h instr=%h t=%0t", pc_o, instr_o, m_head, instr_of(m_head), $time);
        end
      end

      acc   = (icache_req_v_o === 1'b1) && icache_req_rdy_i;
      rsp   = icache_rsp_v_i;
      pop_m = (m_cnt != 0) && instr_rdy_i && !redirect_v_i;
      if (acc) begin
        pending.push_back(icache_adr_o);
        acc_log.push_back(icache_adr_o);
        acc_cnt++;
      end
      if (rsp && pending.size() > 0) void'(pending.pop_front());
      if (instr_v_o === 1'b1 && instr_rdy_i) pop_cnt++;

      if (redirect_v_i) begin
        m_infl  = m_infl + (acc ? 1 : 0) - (rsp ? 1 : 0);
        m_stale = m_infl;
        m_cnt   = 0;
        m_fetch = redirect_pc_i;
        m_head  = redirect_pc_i;
      end else begin
        if (acc) begin
          m_infl++;
          m_fetch = m_fetch + 32'd4;
        end
        if (pop_m) begin
          m_cnt--;
          m_head = m_head + 32'd4;
        end
        if (rsp) begin
          m_infl--;
          if (m_stale > 0) m_stale--;
          else if (byp)    m_head = m_head + 32'd4;
          else             m_cnt++;
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #2;
  endtask

  task automatic do_reset(input logic [31:0] adr);
    cyc();
    reset        = 1'b1;
    reset_adr_i  = adr;
    redirect_v_i = 1'b0;
    cyc();
    cyc();
    acc_log.delete();
    acc_cnt = 0;
    pop_cnt = 0;
    reset   = 1'b0;
  endtask

  task automatic wait_first_pop(input string name, input logic [31:0] exp_pc);
    bit found = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (instr_v_o === 1'b1 && instr_rdy_i) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s no instruction delivered within 60 cycles, required pc=%h", name, exp_pc);
    end else if (pc_o !== exp_pc || instr_o !== instr_of(exp_pc)) begin
      failures++;
      $display("FAIL %s first pc=%h instr=%h required pc=%h instr=%h", name, pc_o, instr_o, exp_pc, instr_of(exp_pc));
    end
  endtask

  task automatic wait_pending(input string name, input int n);
    bit found = 0;
    for (int i = 0; i < 20; i++) begin
      if (pending.size() >= n) begin
        found = 1;
        break;
      end
      cyc();
    end
    checks++;
    if (!found) begin
      failures++;
      $display("FAIL %s in-flight got=%0d required=%0d", name, pending.size(), n);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if (icache_adr_o !== 32'h8000_0000 || icache_req_v_o !== 1'b0 || instr_v_o !== 1'b0 || occupancy_o !== '0) begin
      failures++;
      $display("FAIL test_reset adr=%h req_v=%0b instr_v=%0b occ=%0d required adr=80000000 and zeros",
               icache_adr_o, icache_req_v_o, instr_v_o, occupancy_o);
    end
    cyc();
    acc_log.delete();
    acc_cnt = 0;
    pop_cnt = 0;
    reset   = 1'b0;
  endtask

  task automatic test_sequential();
    int gaps = 0;
    ic_rdy_pct  = 100;
    ic_rsp_pct  = 100;
    instr_rdy_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i >= 2 && instr_v_o !== 1'b1) gaps++;
    end
    checks++;
    if (acc_log.size() < 3 || acc_log[0] !== 32'h8000_0000 || acc_log[1] !== 32'h8000_0004 ||
        acc_log[2] !== 32'h8000_0008) begin
      failures++;
      $display("FAIL seq_req_addrs got %0d accepts first=%h required 80000000,+4,+8",
               acc_log.size(), (acc_log.size() > 0) ? acc_log[0] : 32'hx);
    end
    checks++;
    if (gaps != 0) begin
      failures++;
      $display("FAIL seq_no_gaps got=%0d bubble cycles required=0", gaps);
    end
  endtask

  task automatic test_full();
    instr_rdy_i = 1'b0;
    ic_rdy_pct  = 100;
    ic_rsp_pct  = 100;
    do_reset(32'h8000_0000);
    for (int i = 0; i < 12; i++) @(negedge clk);
    checks++;
    if (acc_cnt != DEPTH || occupancy_o !== CW'(DEPTH) || icache_req_v_o !== 1'b0) begin
      failures++;
      $display("FAIL full accepts=%0d occ=%0d req_v=%0b required accepts=4 occ=4 req_v=0",
               acc_cnt, occupancy_o, icache_req_v_o);
    end
    cyc();
    instr_rdy_i = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_v_o !== 1'b1 || pc_o !== 32'h8000_0000) begin
      failures++;
      $display("FAIL full_drain_head instr_v=%0b pc=%h required 1 and 80000000", instr_v_o, pc_o);
    end
    for (int i = 0; i < 10; i++) @(negedge clk);
    checks++;
    if (pop_cnt < DEPTH) begin
      failures++;
      $display("FAIL full_drain pops=%0d required>=%0d", pop_cnt, DEPTH);
    end
  endtask

  task automatic test_redirect_inflight();
    cyc();
    ic_rsp_pct  = 0;
    ic_rdy_pct  = 100;
    instr_rdy_i = 1'b1;
    wait_pending("redir_setup", 2);
    redirect_v_i  = 1'b1;
    redirect_pc_i = 32'h8000_0100;
    cyc();
    redirect_v_i = 1'b0;
    ic_rsp_pct   = 100;
    wait_first_pop("redir_inflight", 32'h8000_0100);
  endtask

  task automatic test_redirect_with_rsp();
    cyc();
    ic_rsp_pct  = 0;
    ic_rdy_pct  = 100;
    instr_rdy_i = 1'b0;
    wait_pending("redir_rsp_setup", 2);
    ic_rsp_pct = 100;
    cyc();
    ic_rsp_pct = 0;
    wait_pending("redir_rsp_setup2", 2);
    ic_rsp_pct = 100;
    cyc();
    ic_rsp_pct    = 0;
    redirect_v_i  = 1'b1;
    redirect_pc_i = 32'h8000_0300;
    instr_rdy_i   = 1'b1;
    @(negedge clk);
    checks++;
    if (instr_v_o !== 1'b0 || icache_req_v_o !== 1'b0) begin
      failures++;
      $display("FAIL redir_cycle instr_v=%0b req_v=%0b required 0 0", instr_v_o, icache_req_v_o);
    end
    cyc();
    redirect_v_i = 1'b0;
    @(negedge clk);
    checks++;
    if (occupancy_o !== '0) begin
      failures++;
      $display("FAIL redir_flush occ=%0d required=0", occupancy_o);
    end
    cyc();
    ic_rsp_pct = 100;
    wait_first_pop("redir_with_rsp", 32'h8000_0300);
  endtask

  task automatic test_back_to_back();
    cyc();
    ic_rsp_pct    = 60;
    ic_rdy_pct    = 70;
    instr_rdy_i   = 1'b1;
    redirect_v_i  = 1'b1;
    redirect_pc_i = 32'h0000_0100;
    cyc();
    redirect_pc_i = 32'h0000_0200;
    cyc();
    redirect_v_i = 1'b0;
    wait_first_pop("b2b_redirect", 32'h0000_0200);
  endtask

  task automatic test_bypass();
    instr_rdy_i = 1'b1;
    ic_rsp_pct  = 0;
    ic_rdy_pct  = 100;
    do_reset(32'h8000_0400);
    wait_pending("bypass_setup", 1);
    ic_rsp_pct = 100;
    cyc();
    ic_rsp_pct = 0;
    @(negedge clk);
`ifdef FETCH_BUF_BYPASS_EN
    checks++;
    if (instr_v_o !== 1'b1 || instr_o !== 32'h0000_0013 || occupancy_o !== '0) begin
      failures++;
      $display("FAIL bypass_same_cycle instr_v=%0b instr=%h occ=%0d required 1 00000013 0",
               instr_v_o, instr_o, occupancy_o);
    end
`else
    checks++;
    if (instr_v_o !== 1'b0) begin
      failures++;
      $display("FAIL no_bypass_same_cycle instr_v=%0b required=0", instr_v_o);
    end
    @(negedge clk);
    checks++;
    if (instr_v_o !== 1'b1 || instr_o !== 32'h0000_0013 || pc_o !== 32'h8000_0400) begin
      failures++;
      $display("FAIL no_bypass_next_cycle instr_v=%0b instr=%h pc=%h required 1 00000013 80000400",
               instr_v_o, instr_o, pc_o);
    end
`endif
  endtask

  task automatic test_random();
    int start_pops;
    ic_rsp_pct = 50;
    ic_rdy_pct = 60;
    do_reset(32'h8000_0000);
    start_pops = pop_cnt;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      if (i == 1500) begin
        reset_adr_i  = 32'hFFFF_FFF8;
        redirect_v_i = 1'b0;
        reset        = 1'b1;
        cyc();
        cyc();
        reset = 1'b0;
      end else begin
        instr_rdy_i  = ($urandom_range(99) < 70);
        redirect_v_i = ($urandom_range(99) < 3);
        redirect_pc_i = ($urandom_range(3) == 0) ? 32'hFFFF_FFF0 : ($urandom & 32'hFFFF_FFFC);
      end
    end
    cyc();
    redirect_v_i = 1'b0;
    instr_rdy_i  = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (pop_cnt - start_pops < 200) begin
      failures++;
      $display("FAIL random_progress pops=%0d required>=200", pop_cnt - start_pops);
    end
  endtask

  initial begin
    reset         = 1'b1;
    reset_adr_i   = 32'h8000_0000;
    redirect_v_i  = 1'b0;
    redirect_pc_i = '0;
    instr_rdy_i   = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_sequential();
    test_full();
    test_redirect_inflight();
    test_redirect_with_rsp();
    test_back_to_back();
    test_bypass();
    test_random();
    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
